// File: rtl/pwm_generator_if.sv
`default_nettype none
// pwm_generator_if: controller-side request/acknowledge bundle between the angle-to-PWM controller and pwm_generator.
// Revision: 1.0
interface pwm_generator_if;
  logic       pwm_enable;
  logic       pwm_update;
  logic [7:0] pwm_ratio;
  logic       pwm_direction;
  logic       pwm_done;

  modport master (
    output pwm_enable,
    output pwm_update,
    output pwm_ratio,
    output pwm_direction,
    input  pwm_done
  );

  modport slave (
    input  pwm_enable,
    input  pwm_update,
    input  pwm_ratio,
    input  pwm_direction,
    output pwm_done
  );
endinterface
`default_nettype wire

// File: rtl/pwm_generator.sv
`default_nettype none
// pwm_generator: 255-step PWM for the steering H-bridge; ratio changes land on period boundaries, reversals insert coast dead-time.
// Revision: 1.0
module pwm_generator #(
  parameter int unsigned PRESCALE         = 4,
  parameter int unsigned DEADTIME_PERIODS = 2
) (
  input  wire         clock,
  input  wire         reset_n,
  pwm_generator_if.slave ctrl,
  output logic        pwm_out,
  output logic        dir_out,
  output logic [7:0]  active_ratio
);

  localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);
  localparam logic [7:0]  TICK_LAST     = 8'd254;
  localparam logic [3:0]  DEADTIME_INIT = 4'(DEADTIME_PERIODS);

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_RUN      = 2'd1,
    ST_DEADTIME = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] prescale_cnt;
  logic [7:0]  tick_cnt;
  logic        pending;
  logic [3:0]  dead_cnt;
  logic [7:0]  held_ratio;
  logic        held_dir;
  logic        done_q;

  logic tick;
  logic boundary;
  logic take_update;

  assign tick        = (prescale_cnt == PRESCALE_LAST);
  assign boundary    = tick && (tick_cnt == TICK_LAST);
  assign take_update = (state == ST_RUN) && boundary && (pending || ctrl.pwm_update);

  assign ctrl.pwm_done = done_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_OFF;
      prescale_cnt <= '0;
      tick_cnt     <= '0;
      pending      <= 1'b0;
      dead_cnt     <= '0;
      held_ratio   <= '0;
      held_dir     <= 1'b0;
      done_q       <= 1'b0;
      pwm_out      <= 1'b0;
      dir_out      <= 1'b0;
      active_ratio <= '0;
    end else if (!ctrl.pwm_enable) begin
      // Disable wins over everything; dir_out is deliberately kept.
      state        <= ST_OFF;
      prescale_cnt <= '0;
      tick_cnt     <= '0;
      pending      <= 1'b0;
      active_ratio <= '0;
      pwm_out      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      pwm_out <= (state == ST_RUN) && (tick_cnt < active_ratio);
      pending <= (pending || ctrl.pwm_update) && !take_update;

      if (state == ST_OFF) begin
        state <= ST_RUN;
      end else begin
        prescale_cnt <= tick ? 16'd0 : prescale_cnt + 16'd1;
        if (tick) begin
          tick_cnt <= (tick_cnt == TICK_LAST) ? 8'd0 : tick_cnt + 8'd1;
        end

        case (state)
          ST_RUN: begin
            if (take_update) begin
              done_q <= 1'b0;
              if (ctrl.pwm_direction == dir_out) begin
                active_ratio <= ctrl.pwm_ratio;
              end else begin
                // Reversal: coast first, apply the sampled request afterwards.
                held_ratio   <= ctrl.pwm_ratio;
                held_dir     <= ctrl.pwm_direction;
                active_ratio <= '0;
                dead_cnt     <= DEADTIME_INIT;
                state        <= ST_DEADTIME;
              end
            end else if (boundary) begin
              done_q <= 1'b1;
            end
          end
          ST_DEADTIME: begin
            done_q <= 1'b0;
            if (boundary) begin
              if (dead_cnt == 4'd1) begin
                dir_out      <= held_dir;
                active_ratio <= held_ratio;
                state        <= ST_RUN;
              end else begin
                dead_cnt <= dead_cnt - 4'd1;
              end
            end
          end
          default: state <= ST_OFF;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
